// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the GPR write scoreboard.
// Sizes the tracking structures and names the read_type bit positions.
package reg_scoreboard_pkg;

   localparam int SB_MAX_INFLIGHT = 3;
   localparam int SB_NUM_GPR      = 32;
   localparam int RT_RS_BIT       = 0;
   localparam int RT_RT_BIT       = 1;

   typedef logic [4:0] gpr_idx_t;
   typedef logic [1:0] sb_cnt_t;

   // A simultaneous increment and decrement cancel out; both ends saturate.
   function automatic sb_cnt_t sb_cnt_next(input sb_cnt_t cur, input logic inc, input logic dec);
      sb_cnt_t nxt;
      nxt = cur;
      if (inc && !dec && (cur != 2'b11)) begin
         nxt = cur + 2'd1;
      end else if (dec && !inc && (cur != 2'b00)) begin
         nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-GPR pending-write counter: 2-bit saturating up/down counter with
// a synchronous clear that wins over any count request.
module sb_counter
   import reg_scoreboard_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clr_in,
   input  logic    inc_in,
   input  logic    dec_in,
   output sb_cnt_t cnt_out
);

   sb_cnt_t cnt_q;
   sb_cnt_t cnt_d;

   always_comb begin
      cnt_d = sb_cnt_next(cnt_q, inc_in, dec_in);
      if (clr_in) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_out = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard replacing the ID-stage comparator hazard check:
// counts uncommitted writes per GPR and tells ID when it may issue.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       issue_valid_in,
   input  logic       issue_wen_in,
   input  logic [4:0] issue_wnum_in,
   input  logic [4:0] rr1_in,
   input  logic [4:0] rr2_in,
   input  logic [1:0] read_type_in,
   input  logic       retire_valid_in,
   input  logic [4:0] retire_wnum_in,
   input  logic       flush_in,
   output logic       ready_out,
   output logic       busy1_out,
   output logic       busy2_out,
   output logic [1:0] inflight_out,
   output logic       err_out
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

   logic [SB_NUM_GPR-1:0][1:0] cnt_all;
   logic [1:0] inflight_q;
   logic [1:0] inflight_d;
   logic       err_q;
   logic       err_d;
   logic       inc_en;
   logic       dec_en;
   logic       retire_hits;

   // GPR0 is hardwired to zero pending writes, so it is never busy.
   assign cnt_all[0] = '0;

   genvar g;
   generate
      for (g = 1; g < SB_NUM_GPR; g++) begin : g_cnt
         sb_counter u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_in  (flush_in),
            .inc_in  (inc_en && (issue_wnum_in == gpr_idx_t'(g))),
            .dec_in  (dec_en && (retire_wnum_in == gpr_idx_t'(g))),
            .cnt_out (cnt_all[g])
         );
      end
   endgenerate

   assign busy1_out = (cnt_all[rr1_in] != 2'b00);
   assign busy2_out = (cnt_all[rr2_in] != 2'b00);

   // A retire in the same cycle frees a slot, so a full scoreboard may still accept a writer.
   assign ready_out = !(read_type_in[RT_RS_BIT] && busy1_out)
                   && !(read_type_in[RT_RT_BIT] && busy2_out)
                   && !(issue_wen_in && (inflight_q == MAX_CNT) && !retire_valid_in);

   always_comb begin
      retire_hits = retire_valid_in && (retire_wnum_in != 5'd0);
      inc_en      = issue_valid_in && issue_wen_in && (issue_wnum_in != 5'd0) && ready_out;
      dec_en      = retire_hits && (cnt_all[retire_wnum_in] != 2'b00);

      inflight_d = inflight_q;
      if (flush_in) begin
         inflight_d = '0;
      end else if (inc_en && !dec_en && (inflight_q != MAX_CNT)) begin
         inflight_d = inflight_q + 2'd1;
      end else if (dec_en && !inc_en && (inflight_q != 2'd0)) begin
         inflight_d = inflight_q - 2'd1;
      end

      err_d = err_q
            || (issue_valid_in && !ready_out)
            || (retire_hits && (cnt_all[retire_wnum_in] == 2'b00));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign inflight_out = inflight_q;
   assign err_out      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: the driver queues the
// expected outputs of each cycle, a negedge monitor pops and compares them.
module tb_reg_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       issue_valid_in;
   logic       issue_wen_in;
   logic [4:0] issue_wnum_in;
   logic [4:0] rr1_in;
   logic [4:0] rr2_in;
   logic [1:0] read_type_in;
   logic       retire_valid_in;
   logic [4:0] retire_wnum_in;
   logic       flush_in;
   logic       ready_out;
   logic       busy1_out;
   logic       busy2_out;
   logic [1:0] inflight_out;
   logic       err_out;

   typedef struct {
      string      name;
      logic       ready;
      logic       busy1;
      logic       busy2;
      logic [1:0] inflight;
      logic       err;
   } exp_t;

   exp_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;
   bit   driverDone = 1'b0;

   reg_scoreboard #(.MAX_INFLIGHT(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_valid_in  (issue_valid_in),
      .issue_wen_in    (issue_wen_in),
      .issue_wnum_in   (issue_wnum_in),
      .rr1_in          (rr1_in),
      .rr2_in          (rr2_in),
      .read_type_in    (read_type_in),
      .retire_valid_in (retire_valid_in),
      .retire_wnum_in  (retire_wnum_in),
      .flush_in        (flush_in),
      .ready_out       (ready_out),
      .busy1_out       (busy1_out),
      .busy2_out       (busy2_out),
      .inflight_out    (inflight_out),
      .err_out         (err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue that cycle's expected outputs, then advance past the edge.
   task automatic applyStimulus(input string nm,
                                input logic iv, input logic iw, input logic [4:0] wn,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] rt,
                                input logic rv, input logic [4:0] rwn, input logic fl,
                                input logic eReady, input logic eB1, input logic eB2,
                                input logic [1:0] eInf, input logic eErr);
      exp_t e;
      issue_valid_in  = iv;
      issue_wen_in    = iw;
      issue_wnum_in   = wn;
      rr1_in          = r1;
      rr2_in          = r2;
      read_type_in    = rt;
      retire_valid_in = rv;
      retire_wnum_in  = rwn;
      flush_in        = fl;
      e.name     = nm;
      e.ready    = eReady;
      e.busy1    = eB1;
      e.busy2    = eB2;
      e.inflight = eInf;
      e.err      = eErr;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOne(input string nm, input string field, input logic [1:0] act, input logic [1:0] req);
      checkCount++;
      if (act === req) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s.%s actual=%0d required=%0d at %0t", nm, field, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkOne(e.name, "ready",    {1'b0, ready_out}, {1'b0, e.ready});
      checkOne(e.name, "busy1",    {1'b0, busy1_out}, {1'b0, e.busy1});
      checkOne(e.name, "busy2",    {1'b0, busy2_out}, {1'b0, e.busy2});
      checkOne(e.name, "inflight", inflight_out,      e.inflight);
      checkOne(e.name, "err",      {1'b0, err_out},   {1'b0, e.err});
   endtask

   // Monitor: outputs are combinational per cycle, so every negedge presents one response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #200000;
      checkCount++;
      $display("[TB] FAIL watchdog actual=timeout required=completion");
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      issue_valid_in = 0; issue_wen_in = 0; issue_wnum_in = 0;
      rr1_in = 0; rr2_in = 0; read_type_in = 0;
      retire_valid_in = 0; retire_wnum_in = 0; flush_in = 0;
      @(posedge clk);
      #1;
      //              name    iv iw wn  r1  r2  rt     rv rwn fl   rdy b1 b2 inf err
      applyStimulus("rst",   0, 0, 0,  5,  5,  2'b11, 0, 0,  0,   1,  0, 0, 0,  0);
      rst_n = 1'b1;

      // Dependent read of r5 stalls through EXE, MEM and WB.
      applyStimulus("a0",    1, 1, 5,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("a1",    0, 0, 0,  5,  0,  2'b01, 0, 0,  0,   0,  1, 0, 1,  0);
      applyStimulus("a2",    0, 0, 0,  5,  0,  2'b01, 0, 0,  0,   0,  1, 0, 1,  0);
      applyStimulus("a3",    0, 0, 0,  5,  0,  2'b01, 1, 5,  0,   0,  1, 0, 1,  0);
      applyStimulus("a4",    1, 0, 0,  5,  0,  2'b01, 0, 0,  0,   1,  0, 0, 0,  0);

      // Fill all three slots, then a fourth writer with a same-cycle retire.
      applyStimulus("b0",    1, 1, 1,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("b1",    1, 1, 2,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 1,  0);
      applyStimulus("b2",    1, 1, 3,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 2,  0);
      applyStimulus("b3",    0, 1, 4,  1,  3,  2'b00, 0, 0,  0,   0,  1, 1, 3,  0);
      applyStimulus("b4",    1, 1, 4,  1,  3,  2'b00, 1, 1,  0,   1,  1, 1, 3,  0);
      applyStimulus("b5",    0, 0, 0,  1,  4,  2'b00, 0, 0,  0,   1,  0, 1, 3,  0);
      applyStimulus("b6",    0, 0, 0,  0,  0,  2'b00, 1, 2,  0,   1,  0, 0, 3,  0);
      applyStimulus("b7",    0, 0, 0,  0,  0,  2'b00, 1, 3,  0,   1,  0, 0, 2,  0);
      applyStimulus("b8",    0, 0, 0,  0,  0,  2'b00, 1, 4,  0,   1,  0, 0, 1,  0);

      // Issue and retire of the same GPR in one cycle leave its count alone.
      applyStimulus("c0",    1, 1, 7,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("c1",    1, 1, 7,  7,  0,  2'b00, 1, 7,  0,   1,  1, 0, 1,  0);
      applyStimulus("c2",    0, 0, 0,  7,  0,  2'b00, 0, 0,  0,   1,  1, 0, 1,  0);
      applyStimulus("c3",    0, 0, 0,  7,  0,  2'b00, 1, 7,  0,   1,  1, 0, 1,  0);
      applyStimulus("c4",    0, 0, 0,  7,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);

      // GPR0 is never tracked.
      applyStimulus("d0",    1, 1, 0,  0,  0,  2'b11, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("d1",    1, 1, 0,  0,  0,  2'b11, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("d2",    0, 0, 0,  0,  0,  2'b11, 0, 0,  0,   1,  0, 0, 0,  0);

      // Flush drops pending writes and a same-cycle issue; a stale retire sets err.
      applyStimulus("e0",    1, 1, 8,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("e1",    1, 1, 9,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 1,  0);
      applyStimulus("e2",    1, 1, 10, 8,  9,  2'b00, 0, 0,  1,   1,  1, 1, 2,  0);
      applyStimulus("e3",    0, 0, 0,  10, 9,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("e4",    0, 0, 0,  8,  9,  2'b00, 1, 8,  0,   1,  0, 0, 0,  0);
      applyStimulus("e5",    0, 0, 0,  8,  9,  2'b00, 0, 0,  0,   1,  0, 0, 0,  1);

      // Asynchronous reset in the middle of a stall.
      applyStimulus("f0",    1, 1, 5,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  1);
      applyStimulus("f1",    0, 0, 0,  5,  0,  2'b01, 0, 0,  0,   0,  1, 0, 1,  1);
      rst_n = 1'b0;
      applyStimulus("f2",    0, 0, 0,  5,  0,  2'b01, 0, 0,  0,   1,  0, 0, 0,  0);
      rst_n = 1'b1;
      applyStimulus("f3",    0, 0, 0,  5,  0,  2'b01, 0, 0,  0,   1,  0, 0, 0,  0);

      // Issue while not ready is ignored and flagged.
      applyStimulus("g0",    1, 1, 6,  0,  0,  2'b00, 0, 0,  0,   1,  0, 0, 0,  0);
      applyStimulus("g1",    1, 1, 11, 6,  0,  2'b01, 0, 0,  0,   0,  1, 0, 1,  0);
      applyStimulus("g2",    0, 0, 0,  11, 6,  2'b01, 0, 0,  0,   1,  0, 1, 1,  1);
      applyStimulus("g3",    0, 0, 0,  0,  0,  2'b00, 1, 6,  0,   1,  0, 0, 1,  1);
      applyStimulus("g4",    0, 0, 0,  6,  0,  2'b01, 0, 0,  0,   1,  0, 0, 0,  1);

      for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
         @(negedge clk);
      end
      if (expQ.size() > 0) begin
         checkCount++;
         $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
      end
      driverDone = 1'b1;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
